// File: rtl/gdp_pkg.sv
// gdp_pkg: definitions shared by the GDP host-link sequencer files.
//   state_t          - sequencer FSM encoding
//   ST_*             - bit positions inside the transmit status byte
//   DEFAULT_RESULT_W - default width of one engine result word
//   cnt_width()      - counter width for a given terminal count (never 0)
package gdp_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_COLLECT = 3'd2,
    S_SEND    = 3'd3,
    S_TXWAIT  = 3'd4
  } state_t;

  localparam int ST_TIMEOUT = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_SEQ_LSB = 4;

  localparam int DEFAULT_RESULT_W = 16;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: free-running cycle timer with synchronous load-to-zero.
//   clk50M   in  system clock
//   reset    in  asynchronous, active-high
//   load_i   in  clear the count (wins over en_i)
//   en_i     in  advance the count by one
//   expire_o out count has reached TIMEOUT-1
module timeout_counter
  import gdp_pkg::*;
#(
  parameter int TIMEOUT = 1048576
) (
  input  logic clk50M,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/gdp_host_sequencer.sv
// gdp_host_sequencer: host-link sequencer between the PC UART and the GDP engine.
// Latches a received vector, launches the engine, gathers N_RESULTS result
// words (each under a timeout) and hands a status-prefixed frame to the UART.
//   clk50M, reset            clock / asynchronous active-high reset
//   rx_available, rx_bits    received frame strobe and data (byte 0 at [7:0])
//   vec_out, vec_valid       latched vector and one-cycle engine start
//   eng_done, eng_result     engine result strobe and word
//   tx_bits, send_data       transmit frame {slots, status} and start pulse
//   tx_busy                  UART transmitting
//   busy, err_led            not-idle indicator, sticky timeout indicator
module gdp_host_sequencer
  import gdp_pkg::*;
#(
  parameter int N_RX_BYTES = 50,
  parameter int RESULT_W   = DEFAULT_RESULT_W,
  parameter int N_RESULTS  = 4,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                            clk50M,
  input  logic                            reset,
  input  logic                            rx_available,
  input  logic [N_RX_BYTES*8-1:0]         rx_bits,
  output logic [N_RX_BYTES*8-1:0]         vec_out,
  output logic                            vec_valid,
  input  logic                            eng_done,
  input  logic [RESULT_W-1:0]             eng_result,
  output logic [8+N_RESULTS*RESULT_W-1:0] tx_bits,
  output logic                            send_data,
  input  logic                            tx_busy,
  output logic                            busy,
  output logic                            err_led
);

  localparam logic [3:0] LAST_IDX = 4'(N_RESULTS - 1);

  state_t                  state_q, state_d;
  logic [N_RX_BYTES*8-1:0] vec_q;
  logic [7:0]              status_q, status_d;
  logic [3:0]              idx_q, idx_d;
  logic [3:0]              seq_q, seq_d;
  logic                    ovr_q, ovr_d;
  logic                    err_q, err_d;
  logic                    first_q, first_d;   // first TXWAIT cycle: tx_busy not yet valid
  logic                    capture;
  logic                    take_done;
  logic                    tmr_load, tmr_en, tmr_expire;

  assign take_done = (state_q == S_COLLECT) && eng_done;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk50M   (clk50M),
    .reset    (reset),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    ovr_d    = ovr_q;
    err_d    = err_q;
    first_d  = 1'b0;
    capture  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_available) begin
          capture = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        idx_d    = '0;
        tmr_load = 1'b1;
        status_d = '0;
        status_d[ST_OVERRUN] = ovr_q;
        status_d[ST_SEQ_LSB +: 4] = seq_q;
        ovr_d    = 1'b0;
        state_d  = S_COLLECT;
      end
      S_COLLECT: begin
        tmr_en = 1'b1;
        // A done in the expiry cycle still counts as a result.
        if (eng_done) begin
          idx_d    = idx_q + 4'd1;
          tmr_load = 1'b1;
          if (idx_q == LAST_IDX)
            state_d = S_SEND;
        end else if (tmr_expire) begin
          status_d[ST_TIMEOUT] = 1'b1;
          err_d   = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        first_d = 1'b1;
        state_d = S_TXWAIT;
      end
      S_TXWAIT: begin
        if (!first_q && !tx_busy) begin
          seq_d   = seq_q + 4'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Frames arriving while busy are dropped; set after the LAUNCH clear so
    // a frame dropped during LAUNCH is reported on the next one.
    if (rx_available && (state_q != S_IDLE))
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      status_q <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
      first_q  <= first_d;
      if (capture)
        vec_q <= rx_bits;
    end
  end

  // One register per result slot, cleared at launch and loaded when idx matches.
  generate
    for (genvar gi = 0; gi < N_RESULTS; gi++) begin : g_slot
      logic [RESULT_W-1:0] slot_q;
      always_ff @(posedge clk50M or posedge reset) begin
        if (reset)
          slot_q <= '0;
        else if (state_q == S_LAUNCH)
          slot_q <= '0;
        else if (take_done && (idx_q == 4'(gi)))
          slot_q <= eng_result;
      end
      assign tx_bits[8 + gi*RESULT_W +: RESULT_W] = slot_q;
    end
  endgenerate

  assign tx_bits[7:0] = status_q;
  assign vec_out      = vec_q;
  assign vec_valid    = (state_q == S_LAUNCH);
  assign send_data    = (state_q == S_SEND);
  assign busy         = (state_q != S_IDLE);
  assign err_led      = err_q;

endmodule

// File: tb/tb_gdp_host_sequencer.sv
// Directed bench for gdp_host_sequencer (N_RESULTS=4, RESULT_W=16, TIMEOUT=64).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gdp_host_sequencer;

  localparam int NB = 50;
  localparam int RW = 16;
  localparam int NR = 4;
  localparam int TW = 8 + NR*RW;

  logic            clk50M = 1'b0;
  logic            reset;
  logic            rx_available;
  logic [NB*8-1:0] rx_bits;
  logic [NB*8-1:0] vec_out;
  logic            vec_valid;
  logic            eng_done;
  logic [RW-1:0]   eng_result;
  logic [TW-1:0]   tx_bits;
  logic            send_data;
  logic            tx_busy;
  logic            busy;
  logic            err_led;

  int n_cmp = 0;
  int n_bad = 0;
  int send_cnt = 0;
  int vv_cnt = 0;
  int n;

  gdp_host_sequencer #(
    .N_RX_BYTES (NB),
    .RESULT_W   (RW),
    .N_RESULTS  (NR),
    .TIMEOUT    (64)
  ) dut (
    .clk50M       (clk50M),
    .reset        (reset),
    .rx_available (rx_available),
    .rx_bits      (rx_bits),
    .vec_out      (vec_out),
    .vec_valid    (vec_valid),
    .eng_done     (eng_done),
    .eng_result   (eng_result),
    .tx_bits      (tx_bits),
    .send_data    (send_data),
    .tx_busy      (tx_busy),
    .busy         (busy),
    .err_led      (err_led)
  );

  always #10 clk50M = ~clk50M;

  always @(negedge clk50M) begin
    if (send_data) send_cnt++;
    if (vec_valid) vv_cnt++;
  end

  task automatic tick();
    @(negedge clk50M);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse rx_available; ends on the first COLLECT cycle.
  task automatic start_frame(input logic [7:0] b0, input string tag);
    rx_bits = '0;
    rx_bits[7:0] = b0;
    rx_bits[NB*8-1 -: 8] = ~b0;
    rx_available = 1'b1;
    tick();
    rx_available = 1'b0;
    chk({tag, "_vec_valid"}, 128'(vec_valid), 128'(1));
    chk({tag, "_vec_out"}, 128'(vec_out[7:0]), 128'(b0));
    tick();
    chk({tag, "_vec_valid_1cyc"}, 128'(vec_valid), 128'(0));
  endtask

  task automatic give_done(input logic [15:0] r);
    eng_done = 1'b1;
    eng_result = r;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && busy; i++) tick();
    chk({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_vec_valid"}, 128'(vec_valid), 128'(0));
    chk({tag, "_send_data"}, 128'(send_data), 128'(0));
    chk({tag, "_err_led"}, 128'(err_led), 128'(0));
    chk({tag, "_tx_bits"}, 128'(tx_bits), 128'(0));
    chk({tag, "_vec_out"}, 128'(vec_out), 128'(0));
  endtask

  initial begin
    reset = 1'b1;
    rx_available = 1'b0;
    rx_bits = '0;
    eng_done = 1'b0;
    eng_result = '0;
    tx_busy = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Frame 1: four immediate results, seq 0.
    start_frame(8'hA5, "f1");
    chk("f1_status_launch", 128'(tx_bits[7:0]), 128'h00);
    give_done(16'h1111);
    give_done(16'h2222);
    give_done(16'h3333);
    give_done(16'h4444);
    chk("f1_send", 128'(send_data), 128'(1));
    chk("f1_slot3", 128'(tx_bits[TW-1 -: RW]), 128'h4444);
    chk("f1_frame", 128'(tx_bits), 128'h4444_3333_2222_1111_00);
    tx_busy = 1'b1;
    tick();
    chk("f1_send_1cyc", 128'(send_data), 128'(0));
    repeat (9) tick();
    chk("f1_hold_busy", 128'(busy), 128'(1));
    tx_busy = 1'b0;
    wait_idle("f1");
    chk("f1_send_once", 128'(send_cnt), 128'(1));

    // Result strobe while idle is ignored.
    eng_done = 1'b1;
    eng_result = 16'hFFFF;
    tick();
    eng_done = 1'b0;
    chk("idle_done_busy", 128'(busy), 128'(0));
    chk("idle_done_frame", 128'(tx_bits), 128'h4444_3333_2222_1111_00);

    // Frame 2: seq 1, a frame dropped mid-collect.
    start_frame(8'h5A, "f2");
    chk("f2_status_launch", 128'(tx_bits[7:0]), 128'h10);
    give_done(16'hA001);
    rx_available = 1'b1;
    tick();
    rx_available = 1'b0;
    give_done(16'hA002);
    give_done(16'hA003);
    give_done(16'hA004);
    chk("f2_send", 128'(send_data), 128'(1));
    chk("f2_no_relaunch", 128'(vv_cnt), 128'(2));
    chk("f2_frame", 128'(tx_bits), 128'hA004_A003_A002_A001_10);
    // First TXWAIT cycle: tx_busy low and a stray result must both be ignored.
    tick();
    eng_done = 1'b1;
    eng_result = 16'hDEAD;
    tick();
    eng_done = 1'b0;
    chk("f2_txwait_first_ignored", 128'(busy), 128'(1));
    chk("f2_txwait_done_ignored", 128'(tx_bits), 128'hA004_A003_A002_A001_10);
    wait_idle("f2");

    // Frame 3: overrun reported, then timeout after two results.
    start_frame(8'hC3, "f3");
    chk("f3_status_launch", 128'(tx_bits[7:0]), 128'h22);
    give_done(16'hB001);
    give_done(16'hB002);
    // Here we sit one falling edge after the second-done edge; n-1 is the
    // number of rising edges elapsed since that edge when send_data shows.
    n = 1;
    while (!send_data && n < 200) begin
      tick();
      n++;
    end
    chk("f3_timeout_gap", 128'(n - 1), 128'(64));
    chk("f3_frame", 128'(tx_bits), 128'h0000_0000_B002_B001_23);
    chk("f3_err_led", 128'(err_led), 128'(1));
    wait_idle("f3");
    chk("f3_err_sticky", 128'(err_led), 128'(1));

    // Frame 4: last result coincides with timer expiry; the result wins.
    start_frame(8'hE7, "f4");
    chk("f4_status_launch", 128'(tx_bits[7:0]), 128'h30);
    give_done(16'hC001);
    give_done(16'hC002);
    give_done(16'hC003);
    repeat (63) tick();
    chk("f4_no_early_send", 128'(send_data), 128'(0));
    give_done(16'hC004);
    chk("f4_send", 128'(send_data), 128'(1));
    chk("f4_frame", 128'(tx_bits), 128'hC004_C003_C002_C001_30);
    chk("f4_err_still", 128'(err_led), 128'(1));
    wait_idle("f4");

    // Frame 5: reset while waiting on the UART.
    start_frame(8'h11, "f5");
    give_done(16'h0101);
    give_done(16'h0202);
    give_done(16'h0303);
    give_done(16'h0404);
    tx_busy = 1'b1;
    tick();
    chk("f5_in_txwait", 128'(busy), 128'(1));
    reset = 1'b1;
    #1;
    chk_all_zero("rst_txwait");
    tick();
    reset = 1'b0;
    tx_busy = 1'b0;
    tick();

    // Frame 6: reset while collecting; it must never be sent.
    start_frame(8'h22, "f6");
    give_done(16'hD001);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_collect");
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_no_send", 128'(send_cnt), 128'(5));
    chk("rst_still_idle", 128'(busy), 128'(0));

    // Frame 7: normal run after reset, seq back to 0.
    start_frame(8'h33, "f7");
    chk("f7_status_launch", 128'(tx_bits[7:0]), 128'h00);
    give_done(16'h7001);
    give_done(16'h7002);
    give_done(16'h7003);
    give_done(16'h7004);
    chk("f7_send", 128'(send_data), 128'(1));
    chk("f7_frame", 128'(tx_bits), 128'h7004_7003_7002_7001_00);
    wait_idle("f7");
    chk("f7_launch_count", 128'(vv_cnt), 128'(7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
